// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types for the SPI frame controller
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER,
    DRAIN
  } spi_state_e;

  typedef struct packed {
    logic                  last;
    logic [SPI_DATA_W-1:0] data;
  } spi_entry_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO, registered level, fall-through read port
module spi_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; the read port is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - frames a byte stream onto the SPI master under one chip-select
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_last,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_last,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      spi_en,
  output logic [DATA_W-1:0]         spi_mosi_data,
  input  logic [DATA_W-1:0]         spi_miso_data,
  input  logic                      payload_done,
  input  logic                      spi_cs,
  output logic                      busy,
  output logic                      err_abort,
  input  logic                      err_clr,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level
);

  localparam int RLW = $clog2(RX_DEPTH) + 1;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] mosi_q, mosi_d;
  logic              en_q, en_d;
  logic              cur_last_q, cur_last_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  spi_entry_t tx_head, rx_head, rx_push_data;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       rx_room2;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_room2 = (rx_level <= RLW'(RX_DEPTH - 2));

  spi_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .push_data({tx_last, tx_data}),
    .pop(tx_pop), .pop_data(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_data(rx_push_data),
    .pop(rx_pop), .pop_data(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    state_d           = state_q;
    mosi_d            = mosi_q;
    en_d              = en_q;
    cur_last_d        = cur_last_q;
    err_d             = err_clr ? 1'b0 : err_q;
    tx_pop            = 1'b0;
    rx_push           = 1'b0;
    rx_push_data.last = cur_last_q;
    rx_push_data.data = spi_miso_data;
    case (state_q)
      // Looks at the incoming handshake too, so a byte into an idle block starts a cycle sooner.
      IDLE: if ((!tx_empty || tx_push) && spi_cs && !rx_full) state_d = LOAD;
      LOAD: begin
        tx_pop     = 1'b1;
        mosi_d     = tx_head.data;
        cur_last_d = tx_head.last;
        en_d       = 1'b1;
        state_d    = XFER;
      end
      XFER: if (payload_done) begin
        rx_push = 1'b1;
        if (cur_last_q) begin
          en_d    = 1'b0;
          state_d = DRAIN;
        end else if (!tx_empty && rx_room2) begin
          tx_pop     = 1'b1;
          mosi_d     = tx_head.data;
          cur_last_d = tx_head.last;
        end else begin
          rx_push_data.last = 1'b1;
          en_d              = 1'b0;
          err_d             = 1'b1;
          state_d           = DRAIN;
        end
      end
      DRAIN: if (spi_cs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mosi_q     <= '0;
      en_q       <= 1'b0;
      cur_last_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mosi_q     <= mosi_d;
      en_q       <= en_d;
      cur_last_q <= cur_last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign spi_en        = en_q;
  assign spi_mosi_data = mosi_q;
  assign busy          = busy_q;
  assign err_abort     = err_q;
  assign rx_data       = rx_head.data;
  assign rx_last       = rx_head.last;

endmodule
